morse_digit_tx: RTL and testbench
=================================

# morse_digit_tx

Morse transmitter for single decimal digits, the send-side counterpart of the password digit path. It accepts a 4-bit digit on a start strobe and drives a 5-element Morse pattern on `morse_out` with fixed dot, dash and gap durations. Element progress is mirrored on `letterLEDs`. Used to play back prompts and codes on the board LED or buzzer.

## Interface
- `UNIT_CYCLES`, 12_500_000: clock cycles per Morse time unit (250 ms at 50 MHz); minimum 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to transmit `digit`; level-sampled, acted on only in IDLE.
- `digit`  in  4  digit to send, valid 0–9; sampled with `start`.
- `abort`  in  1  synchronous cancel; returns to IDLE next edge.
- `morse_out`  out  1  1 = mark (tone/LED on), 0 = space.
- `busy`  out  1  high from the cycle after acceptance until transmission ends.
- `done`  out  1  one-cycle pulse on normal completion.
- `error`  out  1  one-cycle pulse when `start` is seen in IDLE with `digit` > 9.
- `letterLEDs`  out  5  bit i set when element i finishes its mark; cleared at completion, abort or new start.

## Operation
- States: IDLE, MARK, SPACE, CHARGAP, FINISH.
- IDLE: on `start` with `digit` ≤ 9, latch the digit, clear the element index (3 bits, 0–4), clear the unit counter, clear `letterLEDs`, and go to MARK. On `start` with `digit` > 9, pulse `error` and stay in IDLE.
- Element i is a dash or a dot:
  - digit d in 1–5: elements 0..d-1 are dots, the rest are dashes.
  - d in 6–9: elements 0..d-6 are dashes, the rest are dots.
  - d = 0: all five elements are dashes.
- MARK: `morse_out` = 1 for 1 unit (dot) or 3 units (dash). At the end, set `letterLEDs[i]`. Then:
  - if i < 4, go to SPACE;
  - otherwise go to CHARGAP.
- SPACE: `morse_out` = 0 for 1 unit, then increment i and go to MARK.
- CHARGAP: `morse_out` = 0 for 3 units, then go to FINISH.
- FINISH: one cycle. `done` = 1, `busy` = 0, `letterLEDs` cleared. Next state is IDLE.
- Unit timing: a cycle counter counts 0..UNIT_CYCLES-1 and a unit counter counts units within the state. Both clear on every state entry, so each state lasts exactly N×UNIT_CYCLES cycles.
- `start` while `busy` is ignored. It is not queued.
- `abort` has priority over everything except reset:
  - it takes effect in any non-IDLE state;
  - next edge: IDLE, `morse_out` = 0, `busy` = 0, `letterLEDs` = 0;
  - no `done` pulse.
- `abort` and `start` together in IDLE: abort wins and the start is dropped.

## Timing
- Reset values: `morse_out` 0, `busy` 0, `done` 0, `error` 0, `letterLEDs` 0. State is IDLE and all counters are 0.
- Reset asserted mid-transmission forces the reset values immediately (asynchronous), with no pulse on `done`.
- Start accepted at edge k:
  - `busy` = 1 and `morse_out` = 1 from cycle k+1;
  - zero-cycle latency to the first mark after the accepting edge.
- Total busy time = (marks + 4 + 3) units. Marks are dots×1 + dashes×3, over 4 inter-element spaces.
  - digit 5: 12 units;
  - digit 7: 16 units;
  - digit 0: 22 units.
- `done` is asserted in the cycle immediately after the last CHARGAP cycle. A new `start` is accepted in the cycle after `done`.
- `error` is asserted the cycle after the offending `start` edge. The block stays idle and `busy` never rises.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
- UNIT_CYCLES=4, `start` with digit 5 → `morse_out` shows five 4-cycle highs separated by 4-cycle lows. `busy` is high for 48 cycles, then `done` pulses once. `letterLEDs` steps 00001→11111 and is then cleared.
- UNIT_CYCLES=4, digit 7 → highs of 12, 12, 4, 4, 4 cycles with 4-cycle gaps, then a 12-cycle low. `busy` = 64 cycles.
- UNIT_CYCLES=4, digit 0 → five 12-cycle highs. `busy` = 88 cycles.
- Digit 12 with `start` → single `error` pulse. `busy`, `morse_out` and `letterLEDs` stay 0.
- Digit 1 started; `start` with digit 9 re-pulsed mid-send → ignored, digit-1 waveform unchanged. `abort` during the 3rd element → next cycle all outputs 0, no `done`. A fresh `start` is then accepted normally.
- `rst` driven low during a dash → outputs 0 immediately. After release, digit 6 transmits correctly from element 0.

Source files
------------

// File: rtl/morse_digit_tx.sv
// Morse transmitter for a single decimal digit: plays the 5-element pattern on
// morse_out with unit-based dot/dash/gap timing and mirrors progress on letterLEDs.
module morse_digit_tx #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit,
  input  logic       abort,
  output logic       morse_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] letterLEDs
);

  localparam int CW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_CHARGAP,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    digit_q, digit_d;
  logic [2:0]    elem_q, elem_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    unit_q, unit_d;
  logic          morse_q, morse_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [4:0]    leds_q, leds_d;

  logic       is_dash;
  logic [1:0] state_units;
  logic       unit_end;
  logic       state_end;

  // Digits 1-5 lead with dots, 6-9 lead with dashes, 0 is all dashes.
  always_comb begin
    is_dash = 1'b1;
    if (digit_q == 4'd0) begin
      is_dash = 1'b1;
    end else if (digit_q <= 4'd5) begin
      is_dash = ({1'b0, elem_q} >= digit_q);
    end else begin
      is_dash = ({1'b0, elem_q} <= (digit_q - 4'd6));
    end
  end

  always_comb begin
    state_units = 2'd1;
    case (state_q)
      S_MARK:    state_units = is_dash ? 2'd3 : 2'd1;
      S_CHARGAP: state_units = 2'd3;
      default:   state_units = 2'd1;
    endcase
  end

  assign unit_end  = (cyc_q == CYC_LAST);
  assign state_end = unit_end && (unit_q == (state_units - 2'd1));

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    elem_d  = elem_q;
    cyc_d   = unit_end ? '0 : (cyc_q + CW'(1));
    unit_d  = unit_end ? (unit_q + 2'd1) : unit_q;
    leds_d  = leds_q;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        unit_d = '0;
        if (start && !abort) begin
          if (digit <= 4'd9) begin
            state_d = S_MARK;
            digit_d = digit;
            elem_d  = '0;
            leds_d  = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (state_end) begin
          leds_d[elem_q] = 1'b1;
          state_d = (elem_q == 3'd4) ? S_CHARGAP : S_SPACE;
        end
      end
      S_SPACE: begin
        if (state_end) begin
          elem_d  = elem_q + 3'd1;
          state_d = S_MARK;
        end
      end
      S_CHARGAP: begin
        if (state_end) begin
          state_d = S_FINISH;
          leds_d  = '0;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        leds_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        leds_d  = '0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      leds_d  = '0;
    end

    // Each state's duration is measured from its own entry.
    if (state_d != state_q) begin
      cyc_d  = '0;
      unit_d = '0;
    end

    // Outputs are decoded from the next state so they are registered yet aligned.
    morse_d = (state_d == S_MARK);
    busy_d  = (state_d == S_MARK) || (state_d == S_SPACE) || (state_d == S_CHARGAP);
    done_d  = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      digit_q <= '0;
      elem_q  <= '0;
      cyc_q   <= '0;
      unit_q  <= '0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      elem_q  <= elem_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      morse_q <= morse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      leds_q  <= leds_d;
    end
  end

  assign morse_out  = morse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign letterLEDs = leds_q;

endmodule

// File: tb/tb_morse_digit_tx.sv
// Scoreboard bench for morse_digit_tx: a pattern-level reference model queues the
// expected per-cycle waveform; a monitor compares whatever the DUT presents.
module tb_morse_digit_tx;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] digit;
  logic       abort;
  logic       morse_out;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] letterLEDs;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_cyc[$];
  int         exp_len[$];

  morse_digit_tx #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .digit      (digit),
    .abort      (abort),
    .morse_out  (morse_out),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .letterLEDs (letterLEDs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elem_dash(input int d, input int e);
    if (d == 0) return 1'b1;
    if (d <= 5) return (e >= d);
    return (e <= d - 6);
  endfunction

  // Expected waveform {morse, leds} per busy cycle; ncut<0 means full transmission,
  // otherwise only the first ncut cycles are expected before a cancel/reset.
  function automatic void push_expect(input int d, input int ncut);
    logic [5:0] wave[$];
    int n;
    for (int e = 0; e < 5; e++) begin
      int mlen = elem_dash(d, e) ? 3 : 1;
      for (int c = 0; c < mlen * U; c++) wave.push_back({1'b1, 5'((1 << e) - 1)});
      for (int c = 0; c < ((e < 4) ? U : 3 * U); c++) wave.push_back({1'b0, 5'((1 << (e + 1)) - 1)});
    end
    n = (ncut < 0) ? wave.size() : ncut;
    for (int k = 0; k < n; k++) exp_cyc.push_back(wave[k]);
    exp_len.push_back((ncut < 0) ? n : -n);
  endfunction

  // Monitor
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  int   bsy_cnt   = 0;

  always @(negedge clk) begin
    if (busy) begin
      bsy_cnt++;
      if (exp_cyc.size() == 0) begin
        chk("unexpected_busy", 1, 0);
      end else begin
        logic [5:0] e;
        e = exp_cyc.pop_front();
        chk("morse_out", int'(morse_out), int'(e[5]));
        chk("letterLEDs", int'(letterLEDs), int'(e[4:0]));
      end
    end else if (busy_prev) begin
      if (exp_len.size() == 0) begin
        chk("unexpected_end", 1, 0);
      end else begin
        int l;
        l = exp_len.pop_front();
        chk("busy_len", bsy_cnt, (l > 0) ? l : -l);
        chk("done_at_end", int'(done), (l > 0) ? 1 : 0);
        chk("morse_at_end", int'(morse_out), 0);
        chk("leds_at_end", int'(letterLEDs), 0);
      end
      bsy_cnt = 0;
    end else if (done) begin
      chk("stray_done", 1, 0);
    end
    if (done && done_prev) chk("done_width", 2, 1);
    busy_prev = busy;
    done_prev = done;
  end

  task automatic wait_done(input string name);
    int c;
    for (c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    if (c >= 200) chk({name, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    $display("txn %s: digit=%0d finished after %0d cycles", name, digit, c + 1);
  endtask

  task automatic send(input int d);
    push_expect(d, -1);
    start = 1'b1;
    digit = 4'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("mark_after_start", int'(morse_out), 1);
    wait_done("send");
  endtask

  task automatic send_bad(input int d);
    start = 1'b1;
    digit = 4'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("error_pulse", int'(error), 1);
    chk("busy_on_error", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("error_clear", int'(error), 0);
    chk("busy_after_error", int'(busy), 0);
    chk("morse_after_error", int'(morse_out), 0);
    chk("leds_after_error", int'(letterLEDs), 0);
    $display("txn bad digit=%0d error checked", d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    digit = '0;
    abort = 1'b0;
    #1;
    chk("rst_morse", int'(morse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_leds", int'(letterLEDs), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(5);
    send(7);
    send(0);
    send_bad(12);

    // abort together with start in IDLE drops the start
    start = 1'b1;
    abort = 1'b1;
    digit = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("abort_start_busy2", int'(busy), 0);
    $display("txn abort+start in idle checked");

    // digit 1, ignored restart at cycle 10, abort during third element (cycle 28)
    push_expect(1, 28);
    start = 1'b1;
    digit = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    digit = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_morse", int'(morse_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_leds", int'(letterLEDs), 0);
    chk("abort_done", int'(done), 0);
    $display("txn digit=1 aborted in element 2");
    @(posedge clk);
    #1;
    send(3);

    // asynchronous reset during the first dash of digit 0
    push_expect(0, 5);
    start = 1'b1;
    digit = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_morse", int'(morse_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_leds", int'(letterLEDs), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("txn digit=0 interrupted by reset");
    @(posedge clk);
    #1;
    send(6);

    for (int t = 0; t < 12; t++) begin
      int d;
      d = int'($urandom_range(0, 15));
      if (d > 9) send_bad(d);
      else send(d);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_cycles_left", exp_cyc.size(), 0);
    chk("sb_txns_left", exp_len.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
